// File: rtl/design_switch_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// design_switch_pkg : shared types and sizing helpers for design_switch_sequencer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package design_switch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUIESCE = 2'd1,
      RESET   = 2'd2,
      RUN     = 2'd3
   } state_e;

   // Width of the down-counter shared by the guard and reset phases.
   function automatic int cnt_width(input int guard_cycles, input int reset_cycles);
      int longest;
      longest = (guard_cycles > reset_cycles) ? guard_cycles : reset_cycles;
      return (longest < 1) ? 1 : $clog2(longest + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/design_switch_sequencer_if.sv
// ----------------------------------------------------------------------------
// design_switch_sequencer_if : select, per-design pad bundle and pad-side outputs
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface design_switch_sequencer_if #(
   parameter int NUM_DESIGNS = 12,
   parameter int GPIO_W      = 34,
   parameter int SEL_W       = 4
);
   logic [SEL_W-1:0]              design_select;
   logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_out;
   logic [NUM_DESIGNS*GPIO_W-1:0] designs_gpio_oeb;
   logic [GPIO_W-1:0]             gpio_out;
   logic [GPIO_W-1:0]             gpio_oeb;
   logic [NUM_DESIGNS-1:0]        designs_ncs;
   logic [NUM_DESIGNS-1:0]        designs_n_rst;
   logic [SEL_W-1:0]              active_design;
   logic                          busy;

   modport master (
      input  design_select, designs_gpio_out, designs_gpio_oeb,
      output gpio_out, gpio_oeb, designs_ncs, designs_n_rst, active_design, busy
   );

   modport slave (
      output design_select, designs_gpio_out, designs_gpio_oeb,
      input  gpio_out, gpio_oeb, designs_ncs, designs_n_rst, active_design, busy
   );
endinterface

`default_nettype wire

// File: rtl/design_switch_sequencer_sync_chain.sv
// ----------------------------------------------------------------------------
// sync_chain : multi-stage synchroniser with asynchronous active-low clear
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_chain #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES*WIDTH-1:0] chain;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[(STAGES-1)*WIDTH-1:0], d};
      end
   end

   assign q = chain[STAGES*WIDTH-1 -: WIDTH];

endmodule

`default_nettype wire

// File: rtl/design_switch_sequencer.sv
// ----------------------------------------------------------------------------
// design_switch_sequencer : glitch-free sequenced design select onto shared GPIO
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module design_switch_sequencer
   import design_switch_pkg::*;
#(
   parameter int NUM_DESIGNS  = 12,
   parameter int GPIO_W       = 34,
   parameter int SEL_W        = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int GUARD_CYCLES = 4,
   parameter int RESET_CYCLES = 8
) (
   input  logic                      clk,
   input  logic                      n_rst,
   design_switch_sequencer_if.master bus
);

   localparam int               CNT_W      = cnt_width(GUARD_CYCLES, RESET_CYCLES);
   localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
   localparam logic [SEL_W-1:0] MAX_SEL    = SEL_W'(NUM_DESIGNS);

   localparam logic [1:0] S_IDLE    = IDLE;
   localparam logic [1:0] S_QUIESCE = QUIESCE;
   localparam logic [1:0] S_RESET   = RESET;
   localparam logic [1:0] S_RUN     = RUN;

   logic [1:0]       state;
   logic [SEL_W-1:0] target;
   logic [CNT_W-1:0] cnt;
   logic [SEL_W-1:0] sel_s;
   logic [SEL_W-1:0] sel_v;
   logic             sel_change;

   logic [GPIO_W-1:0]      gpio_out_c;
   logic [GPIO_W-1:0]      gpio_oeb_c;
   logic [NUM_DESIGNS-1:0] ncs_c;
   logic [NUM_DESIGNS-1:0] n_rst_c;

   sync_chain #(
      .WIDTH  (SEL_W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (bus.design_select),
      .q     (sel_s)
   );

   // Out-of-range selects collapse to 0, so "deselect" is just another target.
   assign sel_v      = (sel_s != '0 && sel_s <= MAX_SEL) ? sel_s : '0;
   assign sel_change = (sel_v != target);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= S_IDLE;
         target <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_v != '0) begin
                  target <= sel_v;
                  cnt    <= GUARD_LOAD;
                  state  <= S_QUIESCE;
               end
            end
            S_QUIESCE: begin
               if (sel_change) begin
                  target <= sel_v;
                  cnt    <= GUARD_LOAD;
               end else if (cnt == '0) begin
                  if (target != '0) begin
                     state <= S_RESET;
                     cnt   <= RESET_LOAD;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_RESET: begin
               if (sel_change) begin
                  target <= sel_v;
                  cnt    <= GUARD_LOAD;
                  state  <= S_QUIESCE;
               end else if (cnt == '0) begin
                  state <= S_RUN;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_RUN: begin
               if (sel_change) begin
                  target <= sel_v;
                  cnt    <= GUARD_LOAD;
                  state  <= S_QUIESCE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Decode purely from registered state/target so nothing from the select path glitches the pads.
   always_comb begin
      gpio_out_c = '0;
      gpio_oeb_c = '1;
      ncs_c      = '1;
      n_rst_c    = '0;
      for (int i = 0; i < NUM_DESIGNS; i++) begin
         if (target == SEL_W'(i + 1)) begin
            if (state == S_RESET || state == S_RUN) begin
               ncs_c[i] = 1'b0;
            end
            if (state == S_RUN) begin
               n_rst_c[i] = 1'b1;
               gpio_out_c = bus.designs_gpio_out[i*GPIO_W +: GPIO_W];
               gpio_oeb_c = bus.designs_gpio_oeb[i*GPIO_W +: GPIO_W];
            end
         end
      end
   end

   assign bus.gpio_out      = gpio_out_c;
   assign bus.gpio_oeb      = gpio_oeb_c;
   assign bus.designs_ncs   = ncs_c;
   assign bus.designs_n_rst = n_rst_c;
   assign bus.active_design = (state == S_RUN) ? target : '0;
   assign bus.busy          = (state == S_QUIESCE) || (state == S_RESET);

endmodule

`default_nettype wire
